// File: rtl/delay_unit_pkg.sv
// delay_unit_pkg: shared defaults and requester index type for the delay unit scheduler
package delay_unit_pkg;
  localparam int DATA_WIDTH_DEF = 5;
  localparam int MAX_OUTSTANDING_DEF = 4;
  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_idx_t;
endpackage

// File: rtl/delay_unit_tag_fifo.sv
// delay_unit_tag_fifo: in-order FIFO of requester indices for transfers inside the delay unit
// ports: clk, rst (async, active-high), i_push/i_data write, i_pop read,
//        o_head oldest tag, o_full, o_empty, o_count occupancy
module delay_unit_tag_fifo
  import delay_unit_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_data,
  input  logic                         i_pop,
  output logic                         o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  req_idx_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (i_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= req_idx_t'(i_data);
  assign o_head  = r_mem[r_rd];
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
endmodule

// File: rtl/delay_unit_scheduler.sv
// delay_unit_scheduler: round-robin sharing of one delay unit between two requesters with tagged responses
// ports: CLK, ASYNCRESET (async, active-high); REQ_0/REQ_1 request channels in;
//        DU_IN issue channel out; DU_OUT return channel in; RSP tagged response out;
//        OUTSTANDING in-flight count; ERR sticky orphan-return flag
module delay_unit_scheduler
  import delay_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                                 CLK,
  input  logic                                 ASYNCRESET,
  input  logic [DATA_WIDTH-1:0]                REQ_0_data,
  input  logic                                 REQ_0_valid,
  output logic                                 REQ_0_ready,
  input  logic [DATA_WIDTH-1:0]                REQ_1_data,
  input  logic                                 REQ_1_valid,
  output logic                                 REQ_1_ready,
  output logic [DATA_WIDTH-1:0]                DU_IN_data,
  output logic                                 DU_IN_valid,
  input  logic                                 DU_IN_ready,
  input  logic [DATA_WIDTH-1:0]                DU_OUT_data,
  input  logic                                 DU_OUT_valid,
  output logic                                 DU_OUT_ready,
  output logic [DATA_WIDTH-1:0]                RSP_data,
  output logic                                 RSP_tag,
  output logic                                 RSP_valid,
  input  logic                                 RSP_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] OUTSTANDING,
  output logic                                 ERR
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  req_idx_t      r_last, r_lock_idx, w_grant;
  logic          r_lock, r_err, w_full, w_empty, w_in_fire, w_out_fire, w_head;
  logic [CW-1:0] w_count;
  // a stalled issue keeps its grant so DU_IN_data stays stable while valid is held
  always_comb
    w_grant = r_lock ? r_lock_idx :
              (REQ_0_valid && REQ_1_valid) ? (r_last == REQ0 ? REQ1 : REQ0) :
              (REQ_1_valid ? REQ1 : REQ0);
  // issue is gated on the registered count, so a same-cycle return cannot free a slot early
  assign DU_IN_valid  = !ASYNCRESET && (REQ_0_valid || REQ_1_valid) && !w_full;
  assign DU_IN_data   = w_grant == REQ1 ? REQ_1_data : REQ_0_data;
  assign REQ_0_ready  = !ASYNCRESET && w_grant == REQ0 && DU_IN_ready && !w_full;
  assign REQ_1_ready  = !ASYNCRESET && w_grant == REQ1 && DU_IN_ready && !w_full;
  assign w_in_fire    = DU_IN_valid && DU_IN_ready;
  // returns with nothing in flight are orphans: never forwarded, never acknowledged
  assign RSP_data     = DU_OUT_data;
  assign RSP_tag      = w_head;
  assign RSP_valid    = !ASYNCRESET && DU_OUT_valid && !w_empty;
  assign DU_OUT_ready = !ASYNCRESET && RSP_ready && !w_empty;
  assign w_out_fire   = DU_OUT_valid && DU_OUT_ready;
  assign OUTSTANDING  = w_count;
  assign ERR          = r_err;
  always_ff @(posedge CLK or posedge ASYNCRESET)
    if (ASYNCRESET) begin
      r_last     <= REQ1;
      r_lock     <= 1'b0;
      r_lock_idx <= REQ0;
      r_err      <= 1'b0;
    end else begin
      r_lock     <= DU_IN_valid && !DU_IN_ready;
      r_lock_idx <= w_grant;
      if (w_in_fire) r_last <= w_grant;
      r_err      <= r_err || (DU_OUT_valid && w_empty);
    end
  delay_unit_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (CLK),
    .rst     (ASYNCRESET),
    .i_push  (w_in_fire),
    .i_data  (w_grant),
    .i_pop   (w_out_fire),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
endmodule
